// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, jXX/cmovXX condition
// selectors and the "no register" ID.
package y86_pkg;

    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    localparam logic [3:0] IFUN_ALWAYS = 4'h0;
    localparam logic [3:0] IFUN_LE     = 4'h1;
    localparam logic [3:0] IFUN_L      = 4'h2;
    localparam logic [3:0] IFUN_E      = 4'h3;
    localparam logic [3:0] IFUN_NE     = 4'h4;
    localparam logic [3:0] IFUN_GE     = 4'h5;
    localparam logic [3:0] IFUN_G      = 4'h6;

    localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/cond_eval.sv
// jXX/cmovXX condition evaluator: maps a function code and the ZF/SF/OF flags
// to a taken/move decision. Shared with the fetch-side predictor check.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;

    // SF^OF is the signed "less than" outcome of the last compare/subtract.
    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            IFUN_ALWAYS: cnd = 1'b1;
            IFUN_LE:     cnd = lt | zf;
            IFUN_L:      cnd = lt;
            IFUN_E:      cnd = zf;
            IFUN_NE:     cnd = ~zf;
            IFUN_GE:     cnd = ~lt;
            IFUN_G:      cnd = ~lt & ~zf;
            default:     cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_cc_stage.sv
// Y86-64 execute back end: condition-code register, branch/cmov condition and E/M
// pipeline register. Define EXEC_OVF_COUNT_EN to add the saturating ovf_count output.
module exec_cc_stage
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_valid,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [3:0]       e_stat,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_ovf,
    input  logic [WIDTH-1:0] e_valA,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic             set_cc,
    input  logic             cc_block,
    input  logic             m_stall,
    input  logic             m_bubble,
    output logic             e_cnd,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
`ifdef EXEC_OVF_COUNT_EN
    output logic [31:0]      ovf_count,
`endif
    output logic             M_valid,
    output logic [3:0]       M_icode,
    output logic [3:0]       M_stat,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic             cc_we;
    logic             valid_q, valid_d, cnd_q, cnd_d;
    logic [3:0]       icode_q, icode_d, stat_q, stat_d, dste_q, dste_d, dstm_q, dstm_d;
    logic [WIDTH-1:0] vale_q, vale_d, vala_q, vala_d;

    // A stalled stage must not commit flags, or the replayed OPq would double-write.
    assign cc_we = e_valid & set_cc & ~cc_block & ~m_stall;

    // Condition comes from the registered flags, so a jXX right after an OPq
    // sees that OPq's result one cycle later, never the in-flight ALU value.
    cond_eval u_cond_eval (
        .ifun (e_ifun),
        .zf   (zf_q),
        .sf   (sf_q),
        .of   (of_q),
        .cnd  (e_cnd)
    );

    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (cc_we) begin
            zf_d = (alu_out == '0);
            sf_d = alu_out[WIDTH-1];
            of_d = alu_ovf;
        end
    end

    always_comb begin
        valid_d = valid_q;
        icode_d = icode_q;
        stat_d  = stat_q;
        cnd_d   = cnd_q;
        vale_d  = vale_q;
        vala_d  = vala_q;
        dste_d  = dste_q;
        dstm_d  = dstm_q;
        if (!m_stall) begin
            if (m_bubble || !e_valid) begin
                valid_d = 1'b0;
                icode_d = ICODE_NOP;
                stat_d  = STAT_AOK;
                cnd_d   = 1'b0;
                vale_d  = '0;
                vala_d  = '0;
                dste_d  = REG_NONE;
                dstm_d  = REG_NONE;
            end else begin
                valid_d = 1'b1;
                icode_d = e_icode;
                stat_d  = e_stat;
                cnd_d   = e_cnd;
                vale_d  = alu_out;
                vala_d  = e_valA;
                // A cmov whose condition fails must not write its destination.
                dste_d  = (e_icode == ICODE_CMOVXX && !e_cnd) ? REG_NONE : e_dstE;
                dstm_d  = e_dstM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            valid_q <= 1'b0;
            icode_q <= ICODE_NOP;
            stat_q  <= STAT_AOK;
            cnd_q   <= 1'b0;
            vale_q  <= '0;
            vala_q  <= '0;
            dste_q  <= REG_NONE;
            dstm_q  <= REG_NONE;
        end else begin
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            valid_q <= valid_d;
            icode_q <= icode_d;
            stat_q  <= stat_d;
            cnd_q   <= cnd_d;
            vale_q  <= vale_d;
            vala_q  <= vala_d;
            dste_q  <= dste_d;
            dstm_q  <= dstm_d;
        end
    end

`ifdef EXEC_OVF_COUNT_EN
    logic [31:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (cc_we && alu_ovf && (ovf_cnt_q != 32'hFFFF_FFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`endif

    assign cc_zf   = zf_q;
    assign cc_sf   = sf_q;
    assign cc_of   = of_q;
    assign M_valid = valid_q;
    assign M_icode = icode_q;
    assign M_stat  = stat_q;
    assign M_cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Randomized self-checking bench for exec_cc_stage against a flag/pipeline-register
// reference model; covers the overflow counter when EXEC_OVF_COUNT_EN is defined.
module tb_exec_cc_stage;

    localparam int W = 64;

    typedef struct packed {
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  stat;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] vala;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        zf;
        logic        sf;
        logic        of;
        logic [31:0] ovf;
    } snap_t;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst, e_valid, alu_ovf, set_cc, cc_block, m_stall, m_bubble;
    logic [3:0]    e_icode, e_ifun, e_stat, e_dstE, e_dstM;
    logic [W-1:0]  alu_out, e_valA;
    logic          e_cnd, cc_zf, cc_sf, cc_of;
    logic          M_valid, M_cnd;
    logic [3:0]    M_icode, M_stat, M_dstE, M_dstM;
    logic [W-1:0]  M_valE, M_valA;
`ifdef EXEC_OVF_COUNT_EN
    logic [31:0]   ovf_count;
`endif

    always #5 clk = ~clk;

    exec_cc_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_stat(e_stat), .alu_out(alu_out), .alu_ovf(alu_ovf), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .set_cc(set_cc), .cc_block(cc_block),
        .m_stall(m_stall), .m_bubble(m_bubble), .e_cnd(e_cnd),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
`ifdef EXEC_OVF_COUNT_EN
        .ovf_count(ovf_count),
`endif
        .M_valid(M_valid), .M_icode(M_icode), .M_stat(M_stat), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [$bits(snap_t)-1:0] exp_q[$];
    snap_t       mdl;
    logic        mdl_ready = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Flags describe the last ALU result; SF^OF is its signed "negative" verdict.
    function automatic logic cond_ref(input logic [3:0] f, input snap_t s);
        logic neg;
        neg = s.sf ^ s.of;
        case (f)
            4'd0:    return 1'b1;
            4'd1:    return neg || s.zf;
            4'd2:    return neg;
            4'd3:    return s.zf;
            4'd4:    return !s.zf;
            4'd5:    return !neg;
            4'd6:    return !neg && !s.zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s = '0;
        s.icode = 4'h1;
        s.stat  = 4'h1;
        s.dste  = 4'hF;
        s.dstm  = 4'hF;
        s.zf    = 1'b1;
        return s;
    endfunction

    // Predict the next state from current inputs, clock once, compare everything.
    task automatic tick();
        snap_t nx, got, rs;
        logic  c, we;
        c = cond_ref(e_ifun, mdl);
        if (mdl_ready) check_val("e_cnd", e_cnd, c);
        nx = mdl;
        we = e_valid && set_cc && !cc_block && !m_stall;
        if (rst) begin
            nx = reset_snap();
        end else begin
            if (we) begin
                nx.zf = (alu_out == 64'd0);
                nx.sf = alu_out[63];
                nx.of = alu_ovf;
`ifdef EXEC_OVF_COUNT_EN
                if (alu_ovf && nx.ovf != 32'hFFFF_FFFF) nx.ovf = nx.ovf + 1;
`endif
            end
            if (!m_stall) begin
                if (m_bubble || !e_valid) begin
                    rs = reset_snap();
                    nx.valid = rs.valid; nx.icode = rs.icode; nx.stat = rs.stat;
                    nx.cnd = rs.cnd; nx.vale = rs.vale; nx.vala = rs.vala;
                    nx.dste = rs.dste; nx.dstm = rs.dstm;
                end else begin
                    nx.valid = 1'b1;
                    nx.icode = e_icode;
                    nx.stat  = e_stat;
                    nx.cnd   = c;
                    nx.vale  = alu_out;
                    nx.vala  = e_valA;
                    nx.dste  = (e_icode == 4'h2 && !c) ? 4'hF : e_dstE;
                    nx.dstm  = e_dstM;
                end
            end
        end
        exp_q.push_back(nx);
        mdl = nx;
        mdl_ready = 1'b1;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_val("M_valid", M_valid, got.valid);
        check_val("M_icode", M_icode, got.icode);
        check_val("M_stat",  M_stat,  got.stat);
        check_val("M_cnd",   M_cnd,   got.cnd);
        check_val("M_valE",  M_valE,  got.vale);
        check_val("M_valA",  M_valA,  got.vala);
        check_val("M_dstE",  M_dstE,  got.dste);
        check_val("M_dstM",  M_dstM,  got.dstm);
        check_val("cc_zf",   cc_zf,   got.zf);
        check_val("cc_sf",   cc_sf,   got.sf);
        check_val("cc_of",   cc_of,   got.of);
`ifdef EXEC_OVF_COUNT_EN
        check_val("ovf_count", ovf_count, got.ovf);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] f,
                         input logic [63:0] alu, input logic ovf, input logic sc,
                         input logic [3:0] de, input logic blk, input logic stl,
                         input logic bub, input logic r);
        rst = r; e_valid = v; e_icode = ic; e_ifun = f; alu_out = alu; alu_ovf = ovf;
        set_cc = sc; e_dstE = de; cc_block = blk; m_stall = stl; m_bubble = bub;
        e_valA = {$urandom, $urandom};
        e_stat = 4'($urandom_range(1, 4));
        e_dstM = 4'($urandom_range(0, 15));
        #1;
        tick();
    endtask

    initial begin
        logic [63:0] rnd;
        logic [3:0]  ic;
        rst = 1'b1; e_valid = 1'b0; e_icode = 4'h1; e_ifun = 4'h0; e_stat = 4'h1;
        alu_out = '0; alu_ovf = 1'b0; e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF;
        set_cc = 1'b0; cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        @(posedge clk); #1;

        // Reset, then idle
        drive(0, 4'h1, 4'h0, 64'd0, 0, 0, 4'hF, 0, 0, 0, 1);
        drive(0, 4'h1, 4'h0, 64'd0, 0, 0, 4'hF, 0, 0, 0, 0);
        check_val("rst_zf", cc_zf, 1'b1);
        check_val("rst_icode", M_icode, 4'h1);
        check_val("rst_dstE", M_dstE, 4'hF);
        check_val("rst_valid", M_valid, 1'b0);

        // OPq producing a negative overflowed result, then jl / jge
        drive(1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1, 1, 4'h5, 0, 0, 0, 0);
        check_val("opq_zf", cc_zf, 1'b0);
        check_val("opq_sf", cc_sf, 1'b1);
        check_val("opq_of", cc_of, 1'b1);
        drive(1, 4'h7, 4'h2, 64'h40, 0, 0, 4'hF, 0, 0, 0, 0);
        check_val("jl_cnd", M_cnd, 1'b0);
        drive(1, 4'h7, 4'h5, 64'h40, 0, 0, 4'hF, 0, 0, 0, 0);
        check_val("jge_cnd", M_cnd, 1'b1);

        // cmove with ZF=0 cancels the write; with ZF=1 it goes through
        drive(1, 4'h2, 4'h3, 64'h1234, 0, 0, 4'h3, 0, 0, 0, 0);
        check_val("cmov_cancel_dstE", M_dstE, 4'hF);
        check_val("cmov_cancel_valE", M_valE, 64'h1234);
        drive(1, 4'h6, 4'h0, 64'd0, 0, 1, 4'h2, 0, 0, 0, 0);
        drive(1, 4'h2, 4'h3, 64'h5678, 0, 0, 4'h3, 0, 0, 0, 0);
        check_val("cmov_take_dstE", M_dstE, 4'h3);

        // Blocked CC write: flags unchanged, valE still loaded
        drive(1, 4'h6, 4'h0, 64'd5, 0, 1, 4'h2, 0, 0, 0, 0);
        drive(1, 4'h6, 4'h0, 64'd0, 0, 1, 4'h4, 1, 0, 0, 0);
        check_val("blk_zf", cc_zf, 1'b0);
        check_val("blk_valE", M_valE, 64'd0);

        // Stall with bubble holds everything for 3 cycles, then bubble alone
        for (int i = 0; i < 3; i++)
            drive(1, 4'h6, 4'h0, 64'd0, 1, 1, 4'h7, 0, 1, 1, 0);
        check_val("stall_valE", M_valE, 64'd0);
        check_val("stall_zf", cc_zf, 1'b0);
        drive(1, 4'h6, 4'h0, 64'd9, 0, 0, 4'h7, 0, 0, 1, 0);
        check_val("bub_icode", M_icode, 4'h1);
        check_val("bub_valid", M_valid, 1'b0);

        // Reset while stalled
        drive(1, 4'h6, 4'h0, 64'd3, 0, 1, 4'h1, 0, 0, 0, 0);
        drive(1, 4'h6, 4'h0, 64'd0, 1, 1, 4'h1, 0, 1, 0, 1);
        check_val("rst_stall_valid", M_valid, 1'b0);

`ifdef EXEC_OVF_COUNT_EN
        drive(0, 4'h1, 4'h0, 64'd0, 0, 0, 4'hF, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            drive(1, 4'h6, 4'h0, 64'h7, 1, 1, 4'h1, (i == 1 || i == 3), 0, 0, 0);
        check_val("ovf_count3", ovf_count, 32'd3);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rnd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: ic = 4'h2;
                1: ic = 4'h6;
                2: ic = 4'h7;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            drive($urandom_range(0, 7) != 0, ic, 4'($urandom_range(0, 15)), rnd,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_cc_stage.md
Name: exec_cc_stage

Overview:
- Execute-stage back end of the Y86-64 pipeline; sits directly downstream of the 64-bit ALU wrapper (add/sub/and/xor with overflow flag).
- Captures the ALU result into the condition-code register (ZF/SF/OF).
- Evaluates jXX/cmovXX conditions and registers the executed instruction into the E/M pipeline register.
- Supports stall and bubble control from the pipeline control logic.

Parameters:
- WIDTH, 64, datapath width of valE/valA.
- REG_NONE, 4'hF, register ID meaning "no destination".
- ICODE_NOP, 4'h1, icode inserted on bubble.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- e_valid  in  1  instruction in E is real, not a bubble.
- e_icode  in  4  instruction code.
- e_ifun  in  4  function code; condition selector for jXX/cmovXX.
- e_stat  in  4  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- alu_out  in  WIDTH  ALU result (valE).
- alu_ovf  in  1  ALU signed-overflow bit.
- e_valA  in  WIDTH  pass-through operand.
- e_dstE  in  4  destination for valE.
- e_dstM  in  4  destination for memory read.
- set_cc  in  1  instruction updates CC (OPq only).
- cc_block  in  1  exception in M or W; suppress CC write.
- m_stall  in  1  hold E/M register.
- m_bubble  in  1  load NOP into E/M register.
- e_cnd  out  1  combinational condition result.
- cc_zf, cc_sf, cc_of  out  1 each  current CC register.
- M_valid, M_icode, M_stat, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  1/4/4/1/WIDTH/WIDTH/4/4  E/M register.

Behaviour:
- Single clock domain. All state updates on the rising clk edge. Reset is synchronous and active-high.
- Reset values:
  - cc_zf=1, cc_sf=0, cc_of=0.
  - M_valid=0, M_icode=ICODE_NOP, M_stat=1, M_cnd=0, M_valE=0, M_valA=0, M_dstE=REG_NONE, M_dstM=REG_NONE.
- CC write: occurs when e_valid & set_cc & ~cc_block & ~m_stall.
  - ZF = (alu_out==0).
  - SF = alu_out[WIDTH-1].
  - OF = alu_ovf.
  - Otherwise CC holds.
- e_cnd is purely combinational from the registered CC, never from the in-flight alu_out. Mapping by e_ifun:
  - 0 → 1
  - 1 (le) → (SF^OF)|ZF
  - 2 (l) → SF^OF
  - 3 (e) → ZF
  - 4 (ne) → ~ZF
  - 5 (ge) → ~(SF^OF)
  - 6 (g) → ~(SF^OF)&~ZF
  - 7–15 → 0
- E/M register priority: rst > m_stall (hold all) > m_bubble or ~e_valid (load reset values) > load.
- Load:
  - M_valid=1.
  - M_icode, M_stat, M_valA, M_dstM copied from their E-stage inputs.
  - M_valE=alu_out, M_cnd=e_cnd.
  - M_dstE = REG_NONE if (e_icode==2 & ~e_cnd), else e_dstE (cmov cancel).
- Latency: one cycle from E inputs to M outputs. CC visible on cc_* one cycle after the write; a jXX immediately following an OPq sees the new flags.
- Simultaneous m_stall & m_bubble: stall wins. A set_cc that arrives during a stall does not write the CC.
- rst asserted mid-stall: reset values win on that edge.
- Arithmetic is none internally beyond the 64-bit zero compare; widths are exact with no extension.

Optional Feature:
- Macro: EXEC_OVF_COUNT_EN.
- Defined:
  - Adds output ovf_count (32 bits, reset 0).
  - Increments by 1 on each edge where a CC write occurs with alu_ovf=1.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (NOP=1, CMOVXX=2, OPQ=6, JXX=7).
  - stat codes (AOK=1, HLT=2, ADR=3, INS=4).
  - ifun condition constants (0–6).
  - REG_NONE.
- One sub-module: cond_eval (ifun, zf, sf, of → cnd), reused by the fetch-side branch predictor check.

Test Plan:
- Reset, then idle → cc_zf=1, cc_sf=0, cc_of=0; M_icode=1, M_dstE=4'hF, M_valid=0.
- OPq with set_cc=1, alu_out=64'h8000_0000_0000_0000, alu_ovf=1 → next cycle ZF=0, SF=1, OF=1. A following jXX with ifun=2 gives e_cnd=0; with ifun=5 gives e_cnd=1.
- cmovXX ifun=3 with ZF=0, e_dstE=4'h3 → M_dstE=4'hF, M_valE=alu_out. Repeat with ZF=1 → M_dstE=4'h3.
- set_cc=1, alu_out=0, cc_block=1 → CC unchanged; M_valE=0 still loaded.
- m_stall=1 and m_bubble=1 together with new inputs → M_* and CC hold for 3 cycles. Then bubble only → M_icode=1, M_valid=0.
- With EXEC_OVF_COUNT_EN: 5 OPq with alu_ovf=1, of which 2 have cc_block=1 → ovf_count=3.
